// File: rtl/dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dispatch_ctrl
//   Sequencing front end of the Dispatch stage. Holds one decoded instruction
//   from ID and tracks occupied ROB / RS / LSB slots with credit counters.
//   Dispatch_S fires only when the ROB and the target queue (RS for ALU ops,
//   LSB for loads/stores) both have room; otherwise ID is back-pressured.
//   ROB_clear empties the hold register and the counters, then spends
//   FLUSH_CYCLES cycles in FLUSH before accepting new work.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ID_valid/Op/A/rd/pc  (in)   instruction offered by ID
//   ID_ready            (out)   instruction accepted on this edge
//   Dispatch_S          (out)   held instruction dispatches this cycle
//   Disp_Op/A/rd/pc     (out)   held instruction fields
//   ROB/RS/LSB_release  (in)    one slot freed in the respective queue
//   ROB_clear           (in)    flush (mispredict / rollback)
//   stall               (out)   instruction held but not dispatching
//   perf_stall_cnt      (out)   stall cycles          (DISPATCH_PERF_EN only)
//   perf_full_rob       (out)   stall cycles, ROB full (DISPATCH_PERF_EN only)
//
// Optional feature macro: DISPATCH_PERF_EN adds the two performance counters.
// -----------------------------------------------------------------------------

// Simulation checker: a release pulse arriving at an empty counter is dropped
// by the design and must be flagged.
module dispatch_ctrl_chk #(
    parameter int ROB_W = 5,
    parameter int RS_W  = 5,
    parameter int LSB_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [ROB_W-1:0] rob_cnt,
    input  logic [RS_W-1:0]  rs_cnt,
    input  logic [LSB_W-1:0] lsb_cnt,
    input  logic             rob_alloc,
    input  logic             rs_alloc,
    input  logic             lsb_alloc,
    input  logic             rob_rel,
    input  logic             rs_rel,
    input  logic             lsb_rel
);
    a_rob_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rob_rel && !rob_alloc && !clear && (rob_cnt == '0)));
    a_rs_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(rs_rel && !rs_alloc && !clear && (rs_cnt == '0)));
    a_lsb_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(lsb_rel && !lsb_alloc && !clear && (lsb_cnt == '0)));
endmodule

module dispatch_ctrl #(
    parameter int ROB_SIZE     = 16,
    parameter int RS_SIZE      = 16,
    parameter int LSB_SIZE     = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int OP_W         = 6,
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [OP_W-1:0]   ID_Op,
    input  logic [DATA_W-1:0] ID_A,
    input  logic [REG_W-1:0]  ID_rd,
    input  logic [ADDR_W-1:0] ID_pc,
    output logic              ID_ready,
    output logic              Dispatch_S,
    output logic [OP_W-1:0]   Disp_Op,
    output logic [DATA_W-1:0] Disp_A,
    output logic [REG_W-1:0]  Disp_rd,
    output logic [ADDR_W-1:0] Disp_pc,
    input  logic              ROB_release,
    input  logic              RS_release,
    input  logic              LSB_release,
    input  logic              ROB_clear,
    output logic              stall
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_full_rob
`endif
);
    localparam int ROB_W = $clog2(ROB_SIZE + 1);
    localparam int RS_W  = $clog2(RS_SIZE + 1);
    localparam int LSB_W = $clog2(LSB_SIZE + 1);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);

    // Load/store opcodes of the decoder encoding
    localparam logic [OP_W-1:0] OP_LB  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(12);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(13);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(17);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [FL_W-1:0]   r_flush_cnt, w_flush_nxt;
    logic [ROB_W-1:0]  r_rob_cnt, w_rob_nxt;
    logic [RS_W-1:0]   r_rs_cnt,  w_rs_nxt;
    logic [LSB_W-1:0]  r_lsb_cnt, w_lsb_nxt;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_a;
    logic [REG_W-1:0]  r_rd;
    logic [ADDR_W-1:0] r_pc;

    logic w_is_mem, w_capture;
    logic w_rob_alloc, w_rs_alloc, w_lsb_alloc;

    // Classify the held op: loads/stores go to the LSB, everything else to RS
    always_comb begin
        w_is_mem = 1'b0;
        case (r_op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: w_is_mem = 1'b1;
            default: w_is_mem = 1'b0;
        endcase
    end

    // Handshake outputs; Dispatch_S depends only on registered state and ROB_clear
    always_comb begin
        Dispatch_S = (r_state == ST_HOLD) && !ROB_clear
                     && (r_rob_cnt < ROB_W'(ROB_SIZE))
                     && (w_is_mem ? (r_lsb_cnt < LSB_W'(LSB_SIZE))
                                  : (r_rs_cnt < RS_W'(RS_SIZE)));
        // rst_n gating keeps ID_ready low while reset is held
        ID_ready    = rst_n && (r_state != ST_FLUSH) && !ROB_clear
                      && ((r_state == ST_IDLE) || Dispatch_S);
        stall       = (r_state == ST_HOLD) && !Dispatch_S;
        w_capture   = ID_valid && ID_ready;
        w_rob_alloc = Dispatch_S;
        w_rs_alloc  = Dispatch_S && !w_is_mem;
        w_lsb_alloc = Dispatch_S && w_is_mem;
    end

    // Next-state logic; ROB_clear overrides every state
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        if (ROB_clear) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = FL_W'(FLUSH_CYCLES - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) w_state_nxt = ST_HOLD;
                    else           w_state_nxt = ST_IDLE;
                end
                ST_HOLD: begin
                    // pass-through keeps HOLD when a new op is captured as the old one leaves
                    if (Dispatch_S && !w_capture) w_state_nxt = ST_IDLE;
                    else                          w_state_nxt = ST_HOLD;
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) w_state_nxt = ST_IDLE;
                    else                   w_flush_nxt = r_flush_cnt - FL_W'(1);
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Credit counters: alloc+release cancel, lone release saturates at zero
    always_comb begin
        w_rob_nxt = r_rob_cnt;
        if (ROB_clear)                          w_rob_nxt = '0;
        else if (w_rob_alloc && ROB_release)    w_rob_nxt = r_rob_cnt;
        else if (w_rob_alloc)                   w_rob_nxt = r_rob_cnt + ROB_W'(1);
        else if (ROB_release && r_rob_cnt != '0) w_rob_nxt = r_rob_cnt - ROB_W'(1);
        else                                    w_rob_nxt = r_rob_cnt;

        w_rs_nxt = r_rs_cnt;
        if (ROB_clear)                          w_rs_nxt = '0;
        else if (w_rs_alloc && RS_release)      w_rs_nxt = r_rs_cnt;
        else if (w_rs_alloc)                    w_rs_nxt = r_rs_cnt + RS_W'(1);
        else if (RS_release && r_rs_cnt != '0)  w_rs_nxt = r_rs_cnt - RS_W'(1);
        else                                    w_rs_nxt = r_rs_cnt;

        w_lsb_nxt = r_lsb_cnt;
        if (ROB_clear)                          w_lsb_nxt = '0;
        else if (w_lsb_alloc && LSB_release)    w_lsb_nxt = r_lsb_cnt;
        else if (w_lsb_alloc)                   w_lsb_nxt = r_lsb_cnt + LSB_W'(1);
        else if (LSB_release && r_lsb_cnt != '0) w_lsb_nxt = r_lsb_cnt - LSB_W'(1);
        else                                    w_lsb_nxt = r_lsb_cnt;
    end

    // State, flush timer and credit counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_rob_cnt   <= '0;
            r_rs_cnt    <= '0;
            r_lsb_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
            r_rob_cnt   <= w_rob_nxt;
            r_rs_cnt    <= w_rs_nxt;
            r_lsb_cnt   <= w_lsb_nxt;
        end
    end

    // Hold register for the instruction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_a  <= '0;
            r_rd <= '0;
            r_pc <= '0;
        end else if (w_capture) begin
            r_op <= ID_Op;
            r_a  <= ID_A;
            r_rd <= ID_rd;
            r_pc <= ID_pc;
        end
    end

    assign Disp_Op = r_op;
    assign Disp_A  = r_a;
    assign Disp_rd = r_rd;
    assign Disp_pc = r_pc;

`ifdef DISPATCH_PERF_EN
    // Performance counters survive ROB_clear and wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'd0;
            perf_full_rob  <= 32'd0;
        end else begin
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (stall && (r_rob_cnt == ROB_W'(ROB_SIZE))) perf_full_rob <= perf_full_rob + 32'd1;
        end
    end
`endif

    dispatch_ctrl_chk #(.ROB_W(ROB_W), .RS_W(RS_W), .LSB_W(LSB_W)) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (ROB_clear),
        .rob_cnt   (r_rob_cnt),
        .rs_cnt    (r_rs_cnt),
        .lsb_cnt   (r_lsb_cnt),
        .rob_alloc (w_rob_alloc),
        .rs_alloc  (w_rs_alloc),
        .lsb_alloc (w_lsb_alloc),
        .rob_rel   (ROB_release),
        .rs_rel    (RS_release),
        .lsb_rel   (LSB_release)
    );
endmodule
